// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for a UART: first-word fall-through buffer with sticky
// overrun flag, occupancy count and RTS hysteresis flow control.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int RTS_HIGH   = 12,
  parameter int RTS_LOW    = 4
) (
  input  logic                    uart_clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  input  logic                    overrun_clr,
  output logic                    overrun,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    rts_n
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    RTS_ASSERT = 1'b0,
    RTS_HOLD   = 1'b1
  } rts_state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  r_overrun;
  rts_state_t            r_rts_state;

  logic                  w_wr;
  logic                  w_rd;
  logic [LW-1:0]         w_level_next;
  rts_state_t            w_rts_next;

  assign in_ready  = (r_level != LW'(DEPTH));
  assign out_valid = (r_level != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign overrun   = r_overrun;
  assign level     = r_level;
  assign rts_n     = (r_rts_state == RTS_HOLD);

  // Flush overrides both sides, so a concurrent write or pop never commits.
  assign w_wr = in_valid && in_ready && !flush;
  assign w_rd = out_valid && out_ready && !flush;

  always_comb begin
    w_level_next = r_level;
    if (flush) begin
      w_level_next = '0;
    end else if (w_wr && !w_rd) begin
      w_level_next = r_level + LW'(1);
    end else if (w_rd && !w_wr) begin
      w_level_next = r_level - LW'(1);
    end
  end

  // Hysteresis looks at the occupancy the FIFO will have after this edge.
  always_comb begin
    w_rts_next = r_rts_state;
    if (flush) begin
      w_rts_next = RTS_ASSERT;
    end else begin
      case (r_rts_state)
        RTS_ASSERT: if (w_level_next >= LW'(RTS_HIGH)) w_rts_next = RTS_HOLD;
        RTS_HOLD:   if (w_level_next <= LW'(RTS_LOW))  w_rts_next = RTS_ASSERT;
        default:    w_rts_next = RTS_ASSERT;
      endcase
    end
  end

  always_ff @(posedge uart_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overrun   <= 1'b0;
      r_rts_state <= RTS_ASSERT;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level     <= w_level_next;
      r_rts_state <= w_rts_next;
      // A fresh overrun beats a coincident clear so no event is lost.
      if (in_valid && !in_ready) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          uart_clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          flush;
  logic          overrun_clr;
  logic          overrun;
  logic [LW-1:0] level;
  logic          rts_n;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RTS_HIGH(12), .RTS_LOW(4)) dut (
    .uart_clk    (uart_clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .flush       (flush),
    .overrun_clr (overrun_clr),
    .overrun     (overrun),
    .level       (level),
    .rts_n       (rts_n)
  );

  always #5 uart_clk = ~uart_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, flags derived from its size.
  logic [DW-1:0] m_q[$];
  logic          m_ovr;
  logic          m_rts;

  always @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ovr = 1'b0;
      m_rts = 1'b0;
    end else begin
      automatic bit full = (m_q.size() == DEPTH);
      automatic bit do_rd = (m_q.size() != 0) && out_ready;
      automatic bit do_wr = in_valid && !full;
      if (in_valid && full) m_ovr = 1'b1;
      else if (overrun_clr) m_ovr = 1'b0;
      if (flush) begin
        m_q.delete();
      end else begin
        if (do_rd) void'(m_q.pop_front());
        if (do_wr) m_q.push_back(in_data);
      end
      if (flush) m_rts = 1'b0;
      else if (m_q.size() >= 12) m_rts = 1'b1;
      else if (m_q.size() <= 4) m_rts = 1'b0;
    end
  end

  always @(negedge uart_clk) begin
    chk("mdl_level", 32'(level), 32'(m_q.size()));
    chk("mdl_out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    chk("mdl_in_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
    chk("mdl_overrun", 32'(overrun), 32'(m_ovr));
    chk("mdl_rts_n", 32'(rts_n), 32'(m_rts));
    if (m_q.size() != 0) chk("mdl_out_data", 32'(out_data), 32'(m_q[0]));
  end

  task automatic step(input logic v, input logic [DW-1:0] d, input logic rdy,
                      input logic fl, input logic clr);
    in_valid    = v;
    in_data     = d;
    out_ready   = rdy;
    flush       = fl;
    overrun_clr = clr;
    @(posedge uart_clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; overrun_clr = 1'b0;
    repeat (3) @(posedge uart_clk);
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_rts_n", 32'(rts_n), 0);
    rst_n = 1'b1;
    idle();

    // Three bytes held, then drained on consecutive cycles.
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    chk("lat_out_valid", 32'(out_valid), 1);
    chk("lat_out_data", 32'(out_data), 32'h55);
    step(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
    chk("seq_level3", 32'(level), 3);
    chk("seq_head0", 32'(out_data), 32'h55);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("seq_head1", 32'(out_data), 32'hA3);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("seq_head2", 32'(out_data), 32'h0F);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("seq_empty", 32'(out_valid), 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("seq_underflow_level", 32'(level), 0);

    // Fill to capacity, then offer one byte too many.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_level", 32'(level), 16);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    chk("full_overrun", 32'(overrun), 1);
    chk("full_level_kept", 32'(level), 16);
    step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    chk("full_wr_rd_drop", 32'(level), 15);
    for (int i = 1; i < DEPTH; i++) begin
      chk("drain_data", 32'(out_data), 32'(8'h10 + i));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_empty", 32'(out_valid), 0);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    chk("clr_overrun", 32'(overrun), 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("clr_drained", 32'(level), 0);

    // RTS hysteresis on the way up and down.
    for (int k = 1; k <= 13; k++) begin
      step(1'b1, 8'(k), 1'b0, 1'b0, 1'b0);
      chk("rts_up", 32'(rts_n), 32'(k >= 12));
    end
    for (int k = 12; k >= 0; k--) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("rts_down", 32'(rts_n), 32'(k > 4));
    end

    // Steady level 8 with concurrent write and read; pointers wrap.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 20; j++) begin
      chk("steady_head", 32'(out_data), 32'(8'h40 + j));
      step(1'b1, 8'(8'h48 + j), 1'b1, 1'b0, 1'b0);
      chk("steady_level", 32'(level), 8);
    end

    // Flush at level 10 with rts_n high and a concurrent write.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("pre_flush_level", 32'(level), 10);
    chk("pre_flush_rts", 32'(rts_n), 1);
    step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
    chk("flush_level", 32'(level), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_rts", 32'(rts_n), 0);
    chk("flush_overrun", 32'(overrun), 0);

    // Asynchronous reset mid-stream at level 6.
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_level", 32'(level), 6);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(level), 0);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_overrun", 32'(overrun), 0);
    chk("arst_rts_n", 32'(rts_n), 0);
    @(posedge uart_clk);
    #1 rst_n = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("post_rst_data", 32'(out_data), 32'h3C);
    chk("post_rst_level", 32'(level), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Randomized traffic with phases biased toward full and toward empty.
    for (int i = 0; i < 3000; i++) begin
      automatic int ph   = (i / 300) % 3;
      automatic int pwr  = (ph == 0) ? 90 : (ph == 1) ? 20 : 55;
      automatic int prd  = (ph == 0) ? 20 : (ph == 1) ? 90 : 55;
      automatic logic v  = ($urandom_range(99) < pwr);
      automatic logic r  = ($urandom_range(99) < prd);
      automatic logic fl = ($urandom_range(127) == 0);
      automatic logic cl = ($urandom_range(15) == 0);
      step(v, 8'($urandom), r, fl, cl);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
